usb_tx_packer: RTL and testbench

- Host-bound framer. Reads a payload from a local 256x32 RAM, prefixes one header word, and streams the packet into the FX3 slave-FIFO write port.
- Produces the same header format the receive cache parses: {8'hFF, type_code16, 8'hAA}.
- Sits between the DA-side status/capture buffers and the USB3 pins, on the FX3 interface clock.

---
 rtl/usb_pkt_defs.sv | 37 +++
 rtl/tx_skid_fifo.sv | 60 ++++++
 rtl/usb_tx_packer.sv | 221 ++++++++++++++++++++++
 tb/tb_usb_tx_packer.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/usb_pkt_defs.sv
// Definitions shared by the host-bound packet framer and the receive-side parser:
// header marker bytes, the type-to-code table and the framer state encoding.
package usb_pkt_defs;

  localparam logic [7:0]  HDR_MARK_HI = 8'hFF;
  localparam logic [7:0]  HDR_MARK_LO = 8'hAA;
  localparam logic [31:0] HDR_MASK    = 32'hFF0000FF;
  localparam logic [31:0] HDR_MATCH   = {HDR_MARK_HI, 16'h0000, HDR_MARK_LO};

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_HDR   = 3'd1,
    ST_DATA  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_GAP   = 3'd4
  } tx_state_e;

  function automatic logic tx_type_legal(input logic [2:0] t);
    return (t >= 3'd1) && (t <= 3'd5);
  endfunction

  function automatic logic [15:0] type_code16(input logic [2:0] t);
    case (t)
      3'd1:    return 16'h0000;
      3'd2:    return 16'h000A;
      3'd3:    return 16'h00AA;
      3'd4:    return 16'h0AAA;
      3'd5:    return 16'hAAAA;
      default: return 16'h0000;
    endcase
  endfunction

  function automatic logic [31:0] make_header(input logic [2:0] t);
    return {HDR_MARK_HI, type_code16(t), HDR_MARK_LO};
  endfunction

endpackage

// File: rtl/tx_skid_fifo.sv
// Four-entry skid FIFO absorbing RAM read latency and FLAGB stalls between
// the source RAM and the FX3 write port. Head is visible combinationally.
module tx_skid_fifo #(
  parameter int WIDTH = 32
) (
  input  logic             wrclock,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             empty,
  output logic [2:0]       free_cnt
);

  logic [WIDTH-1:0] mem_q [4];
  logic [1:0]       wr_ptr_q, wr_ptr_d;
  logic [1:0]       rd_ptr_q, rd_ptr_d;
  logic [2:0]       count_q, count_d;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && (count_q != 3'd4);
  assign do_pop  = pop && (count_q != 3'd0);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 2'd1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 2'd1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 3'd1;
      2'b01:   count_d = count_q - 3'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge wrclock or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= 2'd0;
      rd_ptr_q <= 2'd0;
      count_q  <= 3'd0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; the occupancy count alone defines validity.
  always_ff @(posedge wrclock) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

  assign head     = mem_q[rd_ptr_q];
  assign empty    = (count_q == 3'd0);
  assign free_cnt = 3'd4 - count_q;

endmodule

// File: rtl/usb_tx_packer.sv
// Host-bound framer: prefixes a typed header to a payload read from a local RAM
// and streams the packet into the FX3 slave-FIFO write port.
module usb_tx_packer
  import usb_pkt_defs::*;
#(
  parameter int WORD_W      = 32,
  parameter int ADDR_W      = 8,
  parameter int BURST_WORDS = 256,
  parameter int GAP_CYCLES  = 4
) (
  input  logic              wrclock,
  input  logic              rst_n,
  input  logic              tx_req,
  input  logic [2:0]        tx_type,
  input  logic [ADDR_W:0]   tx_len,
  output logic              tx_ack,
  output logic              src_rden,
  output logic [ADDR_W-1:0] src_addr,
  input  logic [WORD_W-1:0] src_data,
  input  logic              USB3_FLAGB,
  output logic              USB3_SLWR_N,
  output logic              USB3_PKTEND_N,
  output logic [WORD_W-1:0] USB3_DQ,
  output logic              busy,
  output logic              err_type,
  output logic              err_marker,
  output logic [15:0]       pkt_count
);

  localparam int LEN_W = ADDR_W + 1;
  localparam int CNT_W = ADDR_W + 2;
  localparam int GAP_W = $clog2(GAP_CYCLES + 1);

  tx_state_e         state_q, state_d;
  logic [2:0]        type_q, type_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [CNT_W-1:0]  total_q, total_d;
  logic              short_q, short_d;
  logic [LEN_W-1:0]  rd_cnt_q, rd_cnt_d;
  logic [CNT_W-1:0]  wr_cnt_q, wr_cnt_d;
  logic [GAP_W-1:0]  gap_cnt_q, gap_cnt_d;
  logic [15:0]       pkt_count_q, pkt_count_d;
  logic              tx_ack_q, tx_ack_d;
  logic              err_type_q, err_type_d;
  logic              err_marker_q, err_marker_d;
  logic              busy_q, busy_d;
  logic              src_rden_q, src_rden_d;
  logic [ADDR_W-1:0] src_addr_q, src_addr_d;
  logic              rvalid_q, rvalid_d;
  logic              slwr_n_q, slwr_n_d;
  logic              pktend_n_q, pktend_n_d;
  logic [WORD_W-1:0] dq_q, dq_d;

  logic              fifo_push;
  logic [WORD_W-1:0] fifo_push_data;
  logic              fifo_pop;
  logic [WORD_W-1:0] fifo_head;
  logic              fifo_empty;
  logic [2:0]        fifo_free;
  logic [2:0]        inflight;
  logic [CNT_W-1:0]  req_total;
  logic              last_pop;
  logic              read_ok;

  // Header goes in during HDR; payload words arrive one cycle after each read.
  assign fifo_push      = (state_q == ST_HDR) || rvalid_q;
  assign fifo_push_data = (state_q == ST_HDR) ? WORD_W'(make_header(type_q)) : src_data;
  assign fifo_pop       = !fifo_empty && USB3_FLAGB;

  assign inflight  = {2'b00, src_rden_q} + {2'b00, rvalid_q};
  assign read_ok   = USB3_FLAGB && (rd_cnt_q < len_q) && (fifo_free >= inflight + 3'd2);
  assign req_total = {1'b0, tx_len} + CNT_W'(1);
  assign last_pop  = (wr_cnt_q + CNT_W'(1)) == total_q;

  tx_skid_fifo #(
    .WIDTH(WORD_W)
  ) u_skid (
    .wrclock   (wrclock),
    .rst_n     (rst_n),
    .push      (fifo_push),
    .push_data (fifo_push_data),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .empty     (fifo_empty),
    .free_cnt  (fifo_free)
  );

  always_comb begin
    state_d      = state_q;
    type_d       = type_q;
    len_d        = len_q;
    total_d      = total_q;
    short_d      = short_q;
    rd_cnt_d     = rd_cnt_q;
    wr_cnt_d     = wr_cnt_q;
    gap_cnt_d    = gap_cnt_q;
    pkt_count_d  = pkt_count_q;
    tx_ack_d     = 1'b0;
    err_type_d   = 1'b0;
    err_marker_d = 1'b0;
    src_rden_d   = 1'b0;
    src_addr_d   = src_addr_q;
    rvalid_d     = src_rden_q;
    slwr_n_d     = 1'b1;
    pktend_n_d   = 1'b1;
    dq_d         = dq_q;

    // Write path runs in every state; word 0 of each packet is the header.
    if (fifo_pop) begin
      slwr_n_d = 1'b0;
      dq_d     = fifo_head;
      wr_cnt_d = wr_cnt_q + CNT_W'(1);
      if ((wr_cnt_q != '0) && ((fifo_head & WORD_W'(HDR_MASK)) == WORD_W'(HDR_MATCH)))
        err_marker_d = 1'b1;
      if (last_pop && short_q)
        pktend_n_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (tx_req) begin
          if (tx_type_legal(tx_type)) begin
            type_d   = tx_type;
            len_d    = tx_len;
            total_d  = req_total;
            short_d  = (32'(req_total) % BURST_WORDS) != 0;
            rd_cnt_d = '0;
            wr_cnt_d = '0;
            tx_ack_d = 1'b1;
            state_d  = ST_HDR;
          end else begin
            err_type_d = 1'b1;
          end
        end
      end
      ST_HDR: begin
        src_addr_d = '0;
        state_d    = (len_q == '0) ? ST_DRAIN : ST_DATA;
      end
      ST_DATA: begin
        if (read_ok) begin
          src_rden_d = 1'b1;
          src_addr_d = rd_cnt_q[ADDR_W-1:0];
          rd_cnt_d   = rd_cnt_q + LEN_W'(1);
        end
        if (rd_cnt_d == len_q) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        // Every word popped means the last SLWR cycle is the current one.
        if (wr_cnt_q == total_q) begin
          pkt_count_d = pkt_count_q + 16'd1;
          gap_cnt_d   = '0;
          state_d     = ST_GAP;
        end
      end
      ST_GAP: begin
        if (gap_cnt_q == GAP_W'(GAP_CYCLES - 1)) state_d = ST_IDLE;
        else gap_cnt_d = gap_cnt_q + GAP_W'(1);
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge wrclock or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      type_q       <= 3'd0;
      len_q        <= '0;
      total_q      <= '0;
      short_q      <= 1'b0;
      rd_cnt_q     <= '0;
      wr_cnt_q     <= '0;
      gap_cnt_q    <= '0;
      pkt_count_q  <= 16'd0;
      tx_ack_q     <= 1'b0;
      err_type_q   <= 1'b0;
      err_marker_q <= 1'b0;
      busy_q       <= 1'b0;
      src_rden_q   <= 1'b0;
      src_addr_q   <= '0;
      rvalid_q     <= 1'b0;
      slwr_n_q     <= 1'b1;
      pktend_n_q   <= 1'b1;
      dq_q         <= '0;
    end else begin
      state_q      <= state_d;
      type_q       <= type_d;
      len_q        <= len_d;
      total_q      <= total_d;
      short_q      <= short_d;
      rd_cnt_q     <= rd_cnt_d;
      wr_cnt_q     <= wr_cnt_d;
      gap_cnt_q    <= gap_cnt_d;
      pkt_count_q  <= pkt_count_d;
      tx_ack_q     <= tx_ack_d;
      err_type_q   <= err_type_d;
      err_marker_q <= err_marker_d;
      busy_q       <= busy_d;
      src_rden_q   <= src_rden_d;
      src_addr_q   <= src_addr_d;
      rvalid_q     <= rvalid_d;
      slwr_n_q     <= slwr_n_d;
      pktend_n_q   <= pktend_n_d;
      dq_q         <= dq_d;
    end
  end

  assign tx_ack        = tx_ack_q;
  assign src_rden      = src_rden_q;
  assign src_addr      = src_addr_q;
  assign USB3_SLWR_N   = slwr_n_q;
  assign USB3_PKTEND_N = pktend_n_q;
  assign USB3_DQ       = dq_q;
  assign busy          = busy_q;
  assign err_type      = err_type_q;
  assign err_marker    = err_marker_q;
  assign pkt_count     = pkt_count_q;

endmodule

// File: tb/tb_usb_tx_packer.sv
// Directed bench for usb_tx_packer: drives packet requests against a RAM model
// and compares the captured FX3 write stream with hand-derived expectations.
module tb_usb_tx_packer;

  logic        wrclock = 1'b0;
  logic        rst_n;
  logic        tx_req;
  logic [2:0]  tx_type;
  logic [8:0]  tx_len;
  logic        tx_ack;
  logic        src_rden;
  logic [7:0]  src_addr;
  logic [31:0] src_data;
  logic        USB3_FLAGB;
  logic        USB3_SLWR_N;
  logic        USB3_PKTEND_N;
  logic [31:0] USB3_DQ;
  logic        busy;
  logic        err_type;
  logic        err_marker;
  logic [15:0] pkt_count;

  logic [31:0] ram [256];
  int          checks = 0;
  int          errors = 0;
  int          exp_pkts = 0;

  always #5 wrclock = ~wrclock;

  always @(posedge wrclock) begin
    if (src_rden) src_data <= ram[src_addr];
  end

  usb_tx_packer dut (
    .wrclock       (wrclock),
    .rst_n         (rst_n),
    .tx_req        (tx_req),
    .tx_type       (tx_type),
    .tx_len        (tx_len),
    .tx_ack        (tx_ack),
    .src_rden      (src_rden),
    .src_addr      (src_addr),
    .src_data      (src_data),
    .USB3_FLAGB    (USB3_FLAGB),
    .USB3_SLWR_N   (USB3_SLWR_N),
    .USB3_PKTEND_N (USB3_PKTEND_N),
    .USB3_DQ       (USB3_DQ),
    .busy          (busy),
    .err_type      (err_type),
    .err_marker    (err_marker),
    .pkt_count     (pkt_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] hdr_of(input logic [2:0] t);
    case (t)
      3'd1:    return 32'hFF0000AA;
      3'd2:    return 32'hFF000AAA;
      3'd3:    return 32'hFF00AAAA;
      3'd4:    return 32'hFF0AAAAA;
      3'd5:    return 32'hFFAAAAAA;
      default: return 32'h00000000;
    endcase
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, "_slwr"},   32'(USB3_SLWR_N),   32'd1);
    check({tag, "_pktend"}, 32'(USB3_PKTEND_N), 32'd1);
    check({tag, "_dq"},     USB3_DQ,            32'd0);
    check({tag, "_rden"},   32'(src_rden),      32'd0);
    check({tag, "_addr"},   32'(src_addr),      32'd0);
    check({tag, "_ack"},    32'(tx_ack),        32'd0);
    check({tag, "_busy"},   32'(busy),          32'd0);
    check({tag, "_errs"},   32'({err_type, err_marker}), 32'd0);
    check({tag, "_pkts"},   32'(pkt_count),     32'd0);
  endtask

  // mode 0: FLAGB high; 1: FLAGB low 10 cycles after 3rd payload write;
  // 2: FLAGB toggles every cycle; 3: reset asserted during payload word 100.
  task automatic run_pkt(input logic [2:0] typ, input logic [8:0] len, input int mode,
                         input string tag);
    logic [31:0] cap_dq [$];
    bit          cap_pe [$];
    bit          cap_em [$];
    logic [31:0] exp_w;
    int          orphan = 0, stall_left = 0, stall_base = 0;
    int          pe_tot = 0, em_tot = 0, em_exp = 0, em_bad = 0;
    bit          stalled = 0, done = 0, aborted = 0, exp_pe;

    @(negedge wrclock);
    tx_type = typ;
    tx_len  = len;
    tx_req  = 1'b1;
    @(negedge wrclock);
    check({tag, "_ack"}, 32'(tx_ack), 32'd1);
    tx_req = 1'b0;

    for (int cyc = 0; cyc < 4000 && !done; cyc++) begin
      @(negedge wrclock);
      if (!USB3_SLWR_N) begin
        cap_dq.push_back(USB3_DQ);
        cap_pe.push_back(!USB3_PKTEND_N);
        cap_em.push_back(err_marker);
      end else begin
        if (!USB3_PKTEND_N) orphan++;
        if (err_marker) orphan++;
      end
      case (mode)
        1: begin
          if (!stalled && cap_dq.size() == 4) begin
            stalled    = 1;
            USB3_FLAGB = 1'b0;
            stall_left = 10;
            stall_base = cap_dq.size();
          end else if (stall_left > 0) begin
            stall_left--;
            if (stall_left == 0) begin
              check({tag, "_stall_quiet"}, 32'(cap_dq.size() - stall_base), 32'd0);
              USB3_FLAGB = 1'b1;
            end
          end
        end
        2: USB3_FLAGB = ~USB3_FLAGB;
        3: begin
          if (cap_dq.size() == 101) begin
            rst_n = 1'b0;
            #1;
            check_reset_outputs({tag, "_async"});
            exp_pkts = 0;
            @(negedge wrclock);
            rst_n   = 1'b1;
            aborted = 1;
            done    = 1;
          end
        end
        default: ;
      endcase
      if (!busy) done = 1;
    end
    USB3_FLAGB = 1'b1;
    if (!done) check({tag, "_timeout"}, 32'd1, 32'd0);

    if (!aborted) begin
      exp_pkts++;
      check({tag, "_nwords"}, 32'(cap_dq.size()), 32'(len) + 32'd1);
      for (int i = 0; i < cap_dq.size(); i++) begin
        exp_w = (i == 0) ? hdr_of(typ) : ram[i-1];
        check($sformatf("%s_w%0d", tag, i), cap_dq[i], exp_w);
        if (cap_pe[i]) pe_tot++;
        if (cap_em[i]) em_tot++;
        if (i > 0 && exp_w[31:24] == 8'hFF && exp_w[7:0] == 8'hAA) begin
          em_exp++;
          if (!cap_em[i]) em_bad++;
        end else if (cap_em[i]) begin
          em_bad++;
        end
      end
      exp_pe = ((32'(len) + 32'd1) % 32'd256) != 32'd0;
      check({tag, "_pktend_cnt"}, 32'(pe_tot), exp_pe ? 32'd1 : 32'd0);
      if (cap_pe.size() > 0)
        check({tag, "_pktend_last"}, 32'(cap_pe[cap_pe.size()-1]), 32'(exp_pe));
      check({tag, "_marker_cnt"}, 32'(em_tot), 32'(em_exp));
      check({tag, "_marker_align"}, 32'(em_bad), 32'd0);
      check({tag, "_orphan"}, 32'(orphan), 32'd0);
      check({tag, "_pkt_count"}, 32'(pkt_count), 32'(exp_pkts));
    end
    $display("packet %s type=%0d len=%0d words=%0d pkt_count=%0d", tag, typ, len,
             cap_dq.size(), pkt_count);
  endtask

  initial begin
    int slwr_seen;
    int busy_seen;

    for (int i = 0; i < 256; i++)
      ram[i] = {8'h12, 8'(i), 8'(255 - i), 8'(i)};
    rst_n      = 1'b0;
    tx_req     = 1'b0;
    tx_type    = 3'd0;
    tx_len     = 9'd0;
    USB3_FLAGB = 1'b1;
    #23;
    check_reset_outputs("reset");
    @(negedge wrclock);
    rst_n = 1'b1;
    repeat (2) @(negedge wrclock);

    run_pkt(3'd1, 9'd4,   0, "t1_len4");
    run_pkt(3'd5, 9'd255, 0, "t5_len255");
    run_pkt(3'd2, 9'd16,  1, "t2_stall");

    // Illegal type: rejected with err_type only.
    @(negedge wrclock);
    tx_type = 3'd6;
    tx_len  = 9'd4;
    tx_req  = 1'b1;
    @(negedge wrclock);
    check("bad_type_err",  32'(err_type), 32'd1);
    check("bad_type_ack",  32'(tx_ack),   32'd0);
    check("bad_type_busy", 32'(busy),     32'd0);
    tx_req    = 1'b0;
    slwr_seen = 0;
    busy_seen = 0;
    repeat (6) begin
      @(negedge wrclock);
      if (!USB3_SLWR_N) slwr_seen++;
      if (busy) busy_seen++;
    end
    check("bad_type_err_clear", 32'(err_type), 32'd0);
    check("bad_type_noslwr",    32'(slwr_seen), 32'd0);
    check("bad_type_noBusy",    32'(busy_seen), 32'd0);
    $display("packet bad_type type=6 err_type pulse, pkt_count=%0d", pkt_count);

    ram[2] = 32'hFF1234AA;
    run_pkt(3'd1, 9'd4, 0, "t1_marker");
    ram[2] = {8'h12, 8'd2, 8'd253, 8'd2};

    run_pkt(3'd4, 9'd20,  2, "t4_toggle");
    run_pkt(3'd3, 9'd0,   0, "t3_hdronly");
    run_pkt(3'd2, 9'd256, 0, "t2_len256");

    run_pkt(3'd3, 9'd200, 3, "t3_reset");
    run_pkt(3'd1, 9'd4,   0, "t1_after_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
